mdu_ctrl: RTL and testbench

//  Sequencer for the EX-stage multiply/divide unit. Accepts MULT/MULTU/DIV/DIVU from the ALU,

---
 rtl/mdu_pkg.sv | 27 ++
 rtl/mdu_sign_fix.sv | 37 +++
 rtl/mdu_ctrl.sv | 191 +++++++++++++++++++
 tb/tb_mdu_ctrl.sv | 257 +++++++++++++++++++++++++
 4 files changed

// File: rtl/mdu_pkg.sv
// Shared encodings for the EX-stage multiply/divide sequencer.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package mdu_pkg;

    // req_op encodings as delivered by the ALU decoder
    localparam logic [1:0] MDU_MULT  = 2'b00;
    localparam logic [1:0] MDU_MULTU = 2'b01;
    localparam logic [1:0] MDU_DIV   = 2'b10;
    localparam logic [1:0] MDU_DIVU  = 2'b11;

    // LO value written by a divide with a zero divisor (HI receives the dividend)
    localparam logic [31:0] DIV0_LO = 32'hFFFF_FFFF;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_MUL_WAIT  = 3'd1,
        ST_DIV_START = 3'd2,
        ST_DIV_WAIT  = 3'd3,
        ST_DONE      = 3'd4
    } mdu_state_t;

    function automatic logic is_mul_op(input logic [1:0] op);
        return (op == MDU_MULT) || (op == MDU_MULTU);
    endfunction

endpackage

// File: rtl/mdu_sign_fix.sv
// Sign handling around the unsigned multiplier: operand magnitudes and product re-sign.
// Latency: purely combinational.
// Backpressure: none; outputs follow inputs.
//
// Ports:
//   val_a/val_b  in  W    raw operands
//   abs_en       in  1    take magnitudes (signed multiply); otherwise pass through
//   mag_a/mag_b  out W    magnitudes or pass-through operands
//   prod_in      in  2W   unsigned product
//   neg_en       in  1    two's-complement negate the product
//   prod_out     out 2W   re-signed product
module mdu_sign_fix #(
    parameter int W = 32
) (
    input  logic [W-1:0]   val_a,
    input  logic [W-1:0]   val_b,
    input  logic           abs_en,
    output logic [W-1:0]   mag_a,
    output logic [W-1:0]   mag_b,
    input  logic [2*W-1:0] prod_in,
    input  logic           neg_en,
    output logic [2*W-1:0] prod_out
);

    // The most negative value maps onto itself, which is the correct unsigned
    // magnitude (2^(W-1)) for the multiplier.
    always_comb begin
        mag_a = (abs_en && val_a[W-1]) ? -val_a : val_a;
        mag_b = (abs_en && val_b[W-1]) ? -val_b : val_b;
    end

    // Negating zero yields zero, so a zero product keeps a clean +0.
    always_comb begin
        prod_out = neg_en ? -prod_in : prod_in;
    end

endmodule

// File: rtl/mdu_ctrl.sv
// Multiply/divide sequencer: latches operands, drives external mul/div, owns HI/LO.
// Latency: MULT/MULTU MUL_LAT+1 cycles to DONE; DIV 2 cycles + divider time; div-by-0 1 cycle.
// Backpressure: stall held combinationally until DONE; flush aborts in any state.
//
// Ports:
//   clk, rst (async, active low)
//   req_valid/req_op/src_a/src_b  operation request from EX
//   flush                         abort; no HI/LO update from the aborted op
//   hi_we/lo_we                   MTHI/MTLO (data = src_a), honoured only when idle
//   stall                         pipeline hold
//   hi/lo                         architectural HI/LO
//   mul_a/mul_b/mul_p             external pipelined unsigned multiplier
//   div_*                         external iterative divider handshake
module mdu_ctrl
    import mdu_pkg::*;
#(
    parameter int MUL_LAT = 5,
    parameter int W       = 32
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           req_valid,
    input  logic [1:0]     req_op,
    input  logic [W-1:0]   src_a,
    input  logic [W-1:0]   src_b,
    input  logic           flush,
    input  logic           hi_we,
    input  logic           lo_we,
    output logic           stall,
    output logic [W-1:0]   hi,
    output logic [W-1:0]   lo,
    output logic [W-1:0]   mul_a,
    output logic [W-1:0]   mul_b,
    input  logic [2*W-1:0] mul_p,
    output logic           div_start,
    output logic           div_signed,
    output logic [W-1:0]   div_a,
    output logic [W-1:0]   div_b,
    output logic           div_annul,
    input  logic [2*W-1:0] div_result,
    input  logic           div_ready
);

    localparam int CNT_W = (MUL_LAT > 1) ? $clog2(MUL_LAT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MUL_LAT - 1);

    mdu_state_t     state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [1:0]     op_q, op_d;
    logic [W-1:0]   a_q, a_d;
    logic [W-1:0]   b_q, b_d;
    logic [W-1:0]   mul_a_q, mul_a_d;
    logic [W-1:0]   mul_b_q, mul_b_d;
    logic [W-1:0]   hi_q, hi_d;
    logic [W-1:0]   lo_q, lo_d;

    logic [W-1:0]   mag_a, mag_b;
    logic [2*W-1:0] prod_fix;
    logic           prod_neg;

    // Magnitudes are computed from the live request so they can be captured on
    // the accept edge; the product fix-up uses the latched operands.
    assign prod_neg = (op_q == MDU_MULT) && (a_q[W-1] ^ b_q[W-1]);

    mdu_sign_fix #(
        .W (W)
    ) u_sign_fix (
        .val_a    (src_a),
        .val_b    (src_b),
        .abs_en   (req_op == MDU_MULT),
        .mag_a    (mag_a),
        .mag_b    (mag_b),
        .prod_in  (mul_p),
        .neg_en   (prod_neg),
        .prod_out (prod_fix)
    );

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        op_d      = op_q;
        a_d       = a_q;
        b_d       = b_q;
        mul_a_d   = mul_a_q;
        mul_b_d   = mul_b_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        div_start = 1'b0;
        div_annul = 1'b0;

        // DONE releases the pipeline while the same instruction is still in EX.
        stall = ((state_q == ST_IDLE) && req_valid && !flush) ||
                (state_q == ST_MUL_WAIT)  ||
                (state_q == ST_DIV_START) ||
                (state_q == ST_DIV_WAIT);

        if (flush) begin
            state_d = ST_IDLE;
            cnt_d   = '0;
            // Start is suppressed (default) so the divider never sees start and
            // annul together.
            if ((state_q == ST_DIV_START) || (state_q == ST_DIV_WAIT)) begin
                div_annul = 1'b1;
            end
        end else begin
            unique case (state_q)
                ST_IDLE: begin
                    if (req_valid) begin
                        op_d    = req_op;
                        a_d     = src_a;
                        b_d     = src_b;
                        mul_a_d = mag_a;
                        mul_b_d = mag_b;
                        if (is_mul_op(req_op)) begin
                            state_d = ST_MUL_WAIT;
                            cnt_d   = '0;
                        end else if (src_b == '0) begin
                            // Divide by zero never reaches the divider.
                            state_d = ST_DONE;
                            hi_d    = src_a;
                            lo_d    = W'(DIV0_LO);
                        end else begin
                            state_d = ST_DIV_START;
                        end
                    end else begin
                        if (hi_we) hi_d = src_a;
                        if (lo_we) lo_d = src_a;
                    end
                end
                ST_MUL_WAIT: begin
                    if (cnt_q == CNT_LAST) begin
                        state_d      = ST_DONE;
                        cnt_d        = '0;
                        {hi_d, lo_d} = prod_fix;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
                ST_DIV_START: begin
                    div_start = 1'b1;
                    state_d   = ST_DIV_WAIT;
                end
                ST_DIV_WAIT: begin
                    if (div_ready) begin
                        state_d      = ST_DONE;
                        {hi_d, lo_d} = div_result;
                    end
                end
                ST_DONE: begin
                    state_d = ST_IDLE;
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            op_q    <= MDU_MULT;
            a_q     <= '0;
            b_q     <= '0;
            mul_a_q <= '0;
            mul_b_q <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            op_q    <= op_d;
            a_q     <= a_d;
            b_q     <= b_d;
            mul_a_q <= mul_a_d;
            mul_b_q <= mul_b_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
        end
    end

    assign hi         = hi_q;
    assign lo         = lo_q;
    assign mul_a      = mul_a_q;
    assign mul_b      = mul_b_q;
    assign div_a      = a_q;
    assign div_b      = b_q;
    assign div_signed = (op_q == MDU_DIV);

endmodule

// File: tb/tb_mdu_ctrl.sv
// Scoreboard bench for mdu_ctrl with behavioural multiplier and divider models.
// Latency: n/a.
// Backpressure: n/a.
module tb_mdu_ctrl;

    logic        clk;
    logic        rst;
    logic        req_valid;
    logic [1:0]  req_op;
    logic [31:0] src_a;
    logic [31:0] src_b;
    logic        flush;
    logic        hi_we;
    logic        lo_we;
    logic        stall;
    logic [31:0] hi;
    logic [31:0] lo;
    logic [31:0] mul_a;
    logic [31:0] mul_b;
    logic [63:0] mul_p;
    logic        div_start;
    logic        div_signed;
    logic [31:0] div_a;
    logic [31:0] div_b;
    logic        div_annul;
    logic [63:0] div_result;
    logic        div_ready;

    mdu_ctrl #(.MUL_LAT(5), .W(32)) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_op     (req_op),
        .src_a      (src_a),
        .src_b      (src_b),
        .flush      (flush),
        .hi_we      (hi_we),
        .lo_we      (lo_we),
        .stall      (stall),
        .hi         (hi),
        .lo         (lo),
        .mul_a      (mul_a),
        .mul_b      (mul_b),
        .mul_p      (mul_p),
        .div_start  (div_start),
        .div_signed (div_signed),
        .div_a      (div_a),
        .div_b      (div_b),
        .div_annul  (div_annul),
        .div_result (div_result),
        .div_ready  (div_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Multiplier: 4 register stages, so the product is present in the last
    // MUL_WAIT cycle when operands are held from the accept edge.
    logic [63:0] mp [0:3];
    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < 4; i++) mp[i] <= 64'd0;
        end else begin
            mp[0] <= {32'd0, mul_a} * {32'd0, mul_b};
            for (int i = 1; i < 4; i++) mp[i] <= mp[i-1];
        end
    end
    assign mul_p = mp[3];

    // Divider: result level-valid 34 cycles after the start edge.
    int dcnt;
    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            dcnt       <= 0;
            div_ready  <= 1'b0;
            div_result <= 64'd0;
        end else if (div_annul) begin
            dcnt      <= 0;
            div_ready <= 1'b0;
        end else if (div_start) begin
            dcnt      <= 34;
            div_ready <= 1'b0;
            if (div_signed)
                div_result <= {32'($signed(div_a) % $signed(div_b)),
                               32'($signed(div_a) / $signed(div_b))};
            else
                div_result <= {div_a % div_b, div_a / div_b};
        end else if (dcnt > 0) begin
            dcnt <= dcnt - 1;
            if (dcnt == 1) div_ready <= 1'b1;
        end
    end

    int          checks;
    int          errors;
    int          n_start;
    int          n_annul;
    logic        hold_moved;
    logic [63:0] exp_q [$];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    // Issue one op held until DONE; expected HI/LO goes to the scoreboard.
    task automatic do_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] ehi, input logic [31:0] elo, input int estall);
        int          n;
        logic [31:0] ha, hb;
        exp_q.push_back({ehi, elo});
        @(posedge clk); #1;
        req_valid = 1'b1; req_op = op; src_a = a; src_b = b;
        n = 0; ha = '0; hb = '0; hold_moved = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (i == 1) begin
                ha = mul_a; hb = mul_b;
            end else if (i > 1 && (mul_a !== ha || mul_b !== hb)) begin
                hold_moved = 1'b1;
            end
            if (!stall) break;
            n++;
        end
        chk("stall_cycles", 64'(n), 64'(estall));
        @(posedge clk); #1;
        req_valid = 1'b0;
    endtask

    task automatic mt(input logic hw, input logic lw, input logic [31:0] v);
        @(posedge clk); #1;
        hi_we = hw; lo_we = lw; src_a = v;
        @(posedge clk); #1;
        hi_we = 1'b0; lo_we = 1'b0;
    endtask

    // Flush an op 'k' edges after it is driven; no result may be produced.
    task automatic flush_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                            input int k, input logic exp_annul);
        @(posedge clk); #1;
        req_valid = 1'b1; req_op = op; src_a = a; src_b = b;
        repeat (k) @(posedge clk);
        #1 flush = 1'b1;
        @(negedge clk);
        chk("annul_in_flush_cycle", 64'(div_annul), 64'(exp_annul));
        @(posedge clk); #1;
        flush = 1'b0; req_valid = 1'b0;
        @(negedge clk);
        chk("stall_after_flush", 64'(stall), 64'd0);
    endtask

    initial begin
        int s0, a0;
        checks = 0; errors = 0; n_start = 0; n_annul = 0; hold_moved = 1'b0;
        rst = 1'b0; req_valid = 1'b0; req_op = 2'b00; src_a = '0; src_b = '0;
        flush = 1'b0; hi_we = 1'b0; lo_we = 1'b0;

        fork
            forever begin
                @(negedge clk);
                if (div_start) n_start++;
                if (div_annul) n_annul++;
                if (rst && req_valid && !stall && !flush) begin
                    if (exp_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_result hi=%h lo=%h with empty scoreboard", hi, lo);
                    end else begin
                        logic [63:0] e;
                        e = exp_q.pop_front();
                        chk("result_hi", 64'(hi), 64'(e[63:32]));
                        chk("result_lo", 64'(lo), 64'(e[31:0]));
                    end
                end
            end
        join_none

        #1;
        chk("reset_stall", 64'(stall), 64'd0);
        chk("reset_hilo", {hi, lo}, 64'd0);
        chk("reset_mul_ops", {mul_a, mul_b}, 64'd0);
        chk("reset_div_pulses", {62'd0, div_start, div_annul}, 64'd0);
        repeat (2) @(negedge clk);
        rst = 1'b1;

        // MULT -3 * 7 = -21
        do_op(2'b00, 32'hFFFF_FFFD, 32'd7, 32'hFFFF_FFFF, 32'hFFFF_FFEB, 6);
        chk("mult_mag_ops", {mul_a, mul_b}, {32'd3, 32'd7});
        chk("mult_ops_held", 64'(hold_moved), 64'd0);

        // MULTU passes operands through unchanged
        do_op(2'b01, 32'hFFFF_FFFF, 32'd2, 32'h0000_0001, 32'hFFFF_FFFE, 6);
        chk("multu_ops", {mul_a, mul_b}, {32'hFFFF_FFFF, 32'd2});
        chk("multu_ops_held", 64'(hold_moved), 64'd0);

        // Most-negative squared, and a negative zero product
        do_op(2'b00, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0, 6);
        do_op(2'b00, 32'h0, 32'hFFFF_FFFB, 32'h0, 32'h0, 6);

        // DIV -7 / 2: quotient -3, remainder -1
        s0 = n_start;
        do_op(2'b10, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 37);
        chk("div_start_pulses", 64'(n_start - s0), 64'd1);

        // DIVU by zero bypasses the divider
        s0 = n_start;
        do_op(2'b11, 32'd5, 32'd0, 32'd5, 32'hFFFF_FFFF, 1);
        chk("div0_no_start", 64'(n_start - s0), 64'd0);

        // DIVU 100 / 7 = 14 rem 2
        do_op(2'b11, 32'd100, 32'd7, 32'd2, 32'd14, 37);

        // MTHI/MTLO in the same cycle
        mt(1'b1, 1'b1, 32'h11);
        @(negedge clk);
        chk("mthi_mtlo", {hi, lo}, {32'h11, 32'h11});

        // Flush 3 cycles into DIV_WAIT
        s0 = n_start; a0 = n_annul;
        flush_op(2'b10, 32'd100, 32'd3, 5, 1'b1);
        chk("flush_div_annul_count", 64'(n_annul - a0), 64'd1);
        chk("flush_div_start_count", 64'(n_start - s0), 64'd1);
        chk("flush_div_hilo", {hi, lo}, {32'h11, 32'h11});

        // Flush mid multiply: no annul, no write
        a0 = n_annul;
        flush_op(2'b00, 32'd9, 32'd9, 3, 1'b0);
        chk("flush_mul_annul_count", 64'(n_annul - a0), 64'd0);
        repeat (8) @(negedge clk);
        chk("flush_mul_hilo", {hi, lo}, {32'h11, 32'h11});

        // Async reset mid MUL_WAIT
        @(posedge clk); #1;
        req_valid = 1'b1; req_op = 2'b00; src_a = 32'd9; src_b = 32'd9;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0; req_valid = 1'b0;
        #1;
        chk("rst_mid_stall", 64'(stall), 64'd0);
        chk("rst_mid_hilo", {hi, lo}, 64'd0);
        chk("rst_mid_mul_a", 64'(mul_a), 64'd0);
        @(negedge clk);
        rst = 1'b1;
        mt(1'b1, 1'b0, 32'h0000_ABCD);
        @(negedge clk);
        chk("mthi_after_rst", {hi, lo}, {32'h0000_ABCD, 32'h0});

        repeat (10) @(negedge clk);
        chk("scoreboard_drained", 64'(exp_q.size()), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
